matmul_sched: RTL and testbench

- Round-robin scheduler that shares one 2x2 matrix-multiplier datapath (4-bit elements, 8-bit results) among NUM_REQ requesters.
- Accepts operand pairs through per-requester valid/ready handshakes and latches the winner's operands.
- Pulses the multiplier start, waits for its done, and returns the packed result to the owning requester under a valid/ready handshake.
- Includes a watchdog that frees the datapath if done never arrives.

---
 rtl/matmul_sched.sv | 125 ++++++++++++
 tb/tb_matmul_sched.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sched.sv
// Round-robin scheduler sharing one 2x2 matrix-multiplier datapath among NUM_REQ requesters.
// Operands are latched on accept, the multiplier is started, and its result is returned to the owner.
module matmul_sched #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*16-1:0]  req_a,
  input  logic [NUM_REQ*16-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_c,
  output logic                   rsp_err,
  output logic [15:0]            mm_a,
  output logic [15:0]            mm_b,
  output logic                   mm_start,
  input  logic [31:0]            mm_c,
  input  logic                   mm_done,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
  // valid never waits on ready, and the payload is stable while valid is high and unaccepted.

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   idx;
  logic              found;
  logic              done_q;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              done_edge;
  logic              timeout;
  logic              rsp_hs;

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign accept    = (state == IDLE) && found;
  assign done_edge = mm_done && !done_q;
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_hs    = rsp_ready[grant_id];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (done_edge || timeout) state_nxt = RESP;
      RESP:  if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
    rsp_valid = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
    mm_start  = (state == ISSUE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      done_q   <= 1'b0;
      cnt      <= '0;
      rsp_c    <= '0;
      rsp_err  <= 1'b0;
    end else begin
      done_q <= mm_done;
      case (state)
        IDLE: if (accept) begin
          mm_a     <= req_a[int'(winner)*16 +: 16];
          mm_b     <= req_b[int'(winner)*16 +: 16];
          grant_id <= winner;
          rr_ptr   <= winner;
        end
        ISSUE: cnt <= '0;
        // A real done edge beats a timeout landing in the same cycle.
        WAIT: begin
          if (done_edge) begin
            rsp_c   <= mm_c;
            rsp_err <= 1'b0;
          end else if (timeout) begin
            rsp_c   <= '0;
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: behavioural multiplier, reference arbiter and product model,
// directed scenarios followed by randomized traffic.
module tb_matmul_sched;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*16-1:0] req_a, req_b;
  logic [31:0]           rsp_c, mm_c;
  logic                  rsp_err, mm_start, mm_done, busy;
  logic [15:0]           mm_a, mm_b;
  logic [ID_W-1:0]       grant_id;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          mm_mode  = 0;  // 0 pulse done, 1 hold done high, 2 never done
  int          mm_lat   = 4;
  int          last_g   = NUM_REQ - 1;
  logic [31:0] exp_q[$];

  matmul_sched #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(TIMEOUT), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_err(rsp_err),
    .mm_a(mm_a), .mm_b(mm_b), .mm_start(mm_start), .mm_c(mm_c), .mm_done(mm_done),
    .busy(busy), .grant_id(grant_id)
  );

  // clock / safety limit
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // 2x2 product of nibble matrices, each result byte truncated to 8 bits
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea[4];
    int eb[4];
    int s;
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      ea[n] = int'((a >> (12 - 4*n)) & 16'hf);
      eb[n] = int'((b >> (12 - 4*n)) & 16'hf);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = ea[2*i]*eb[j] + ea[2*i+1]*eb[2+j];
        r = (r << 8) | 32'(s & 255);
      end
    return r;
  endfunction

  // round-robin: first pending requester after the previous winner
  function automatic int pick(input int last, input logic [NUM_REQ-1:0] mask);
    for (int k = 1; k <= NUM_REQ; k++)
      if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  // behavioural multiplier: done rises L cycles after the start cycle
  initial begin
    logic [15:0] a, b;
    int mode, lat;
    mm_done = 1'b0;
    mm_c    = '0;
    forever begin
      @(negedge clk);
      if (mm_start) begin
        a = mm_a; b = mm_b; mode = mm_mode; lat = mm_lat;
        if (mode != 2) begin
          repeat (lat - 1) @(posedge clk);
          #1 mm_done = 1'b0;
          @(posedge clk);
          #1 mm_done = 1'b1;
          mm_c = ref_mul(a, b);
          if (mode == 0) begin
            @(posedge clk);
            #1 mm_done = 1'b0;
            mm_c = $urandom;
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    last_g = NUM_REQ - 1;
    exp_q.delete();
  endtask

  // Driver for one full transaction; called just after a rising edge with the FSM in IDLE.
  task automatic serve(input int bp, output int who);
    int k, starts;
    bit stray, exp_err;
    int exp_lat;
    logic [15:0] ea, eb;
    logic [31:0] got_c, exp_c;
    who = pick(last_g, req_valid);
    if (who < 0) begin
      check("serve_pending", 64'(req_valid), 64'hf);
      return;
    end
    @(negedge clk);
    check("idle_before_accept", {busy, rsp_valid}, 0);
    check("req_ready", req_ready, 64'(1 << who));
    ea      = req_a[16*who +: 16];
    eb      = req_b[16*who +: 16];
    exp_err = (mm_mode == 2);
    exp_lat = exp_err ? TIMEOUT + 2 : mm_lat + 2;
    exp_q.push_back(exp_err ? 32'h0 : ref_mul(ea, eb));
    last_g = who;
    @(posedge clk);
    #1 req_valid[who] = 1'b0;
    k = 0; starts = 0; stray = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check("grant_id", grant_id, 64'(who));
        check("mm_ab", {mm_a, mm_b}, {ea, eb});
      end
      if (mm_start) starts++;
      if (req_ready != 0 || !busy) stray = 1;
    end while (rsp_valid == 0 && k < TIMEOUT + 20);
    check("mm_start_pulses", starts, 1);
    check("busy_no_accept", stray, 0);
    check("rsp_latency", k, exp_lat);
    check("rsp_valid", rsp_valid, 64'(1 << who));
    check("rsp_err", rsp_err, 64'(exp_err));
    got_c = rsp_c;
    exp_c = exp_q.pop_front();
    check("rsp_c", got_c, exp_c);
    stray = 0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1 rsp_ready = ~(4'b1 << who);
      @(negedge clk);
      if (rsp_valid != 4'(1 << who) || rsp_c !== got_c || req_ready != 0 || !busy) stray = 1;
    end
    if (bp > 0) check("backpressure_stable", stray, 0);
    @(posedge clk);
    #1 rsp_ready = 4'(1 << who);
    @(posedge clk);
    #1 rsp_ready = '0;
  endtask

  initial begin
    int who;
    int nxt;
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {req_ready, rsp_valid, mm_start, busy, grant_id, rsp_err}, 0);
    check("reset_data", {rsp_c, mm_a, mm_b}, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // single request, then a second job with done still held high
    mm_mode = 1; mm_lat = 4;
    set_req(2, 16'h1234, 16'h5678);
    serve(0, who);
    check("t1_owner", who, 2);
    check("t1_c", rsp_c, 32'h13162B32);
    set_req(0, 16'h2013, 16'h1420);
    serve(0, who);
    check("t2_owner", who, 0);
    check("t2_c", rsp_c, 32'h02080704);

    // fairness with all four pending from reset, backpressure on the second
    do_reset();
    mm_mode = 0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'($urandom), 16'($urandom));
    for (int i = 0; i < NUM_REQ; i++) begin
      mm_lat = $urandom_range(2, 6);
      serve(i == 1 ? 5 : 0, who);
      check("fair4_order", who, i);
    end

    // after a grant to 1, requesters 0 and 3 are served as 3 then 0
    set_req(1, 16'($urandom), 16'($urandom));
    serve(0, who);
    set_req(0, 16'($urandom), 16'($urandom));
    set_req(3, 16'($urandom), 16'($urandom));
    serve(0, who);
    check("after1_first", who, 3);
    serve(0, who);
    check("after1_second", who, 0);

    // timeout, then a normal job
    mm_mode = 2;
    set_req($urandom_range(0, 3), 16'($urandom), 16'($urandom));
    serve(0, who);
    mm_mode = 0; mm_lat = 3;
    set_req($urandom_range(0, 3), 16'($urandom), 16'($urandom));
    serve(0, who);

    // reset asserted while waiting on the multiplier
    mm_mode = 2;
    set_req(3, 16'($urandom), 16'($urandom));
    @(negedge clk);
    check("rst_wait_accept", req_ready, 4'b1000);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1 check("rst_async_ctrl", {req_ready, rsp_valid, mm_start, busy, grant_id, rsp_err}, 0);
    check("rst_async_data", {rsp_c, mm_a, mm_b}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    last_g = NUM_REQ - 1;
    exp_q.delete();
    nxt = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid != 0 || busy) nxt = 1;
    end
    check("rst_no_rsp", nxt, 0);
    @(posedge clk);
    #1 mm_mode = 0; mm_lat = 4;
    set_req(1, 16'($urandom), 16'($urandom));
    set_req(0, 16'($urandom), 16'($urandom));
    serve(0, who);
    check("rst_then_first", who, 0);
    serve(0, who);
    check("rst_then_second", who, 1);

    // randomized traffic
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, 16'($urandom), 16'($urandom));
      if (req_valid == 0) set_req($urandom_range(0, 3), 16'($urandom), 16'($urandom));
      mm_mode = $urandom_range(0, 1);
      mm_lat  = $urandom_range(2, 8);
      nxt     = pick(last_g, req_valid);
      serve($urandom_range(0, 3), who);
      check("rand_owner", who, nxt);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
